// File: rtl/a2d_spi_master_if.sv
// ---------------------------------------------------------------------------
// a2d_spi_master_if
// Bundles the conversion handshake and the A2D SPI pins of a2d_spi_master.
//   strt_cnv  : single-cycle conversion request (from sampling logic)
//   chnnl     : channel to convert, sampled with an accepted strt_cnv
//   cnv_cmplt : level, high while res holds a valid result
//   res       : last 12-bit conversion result
//   SS_n      : active-low slave select to the A2D
//   SCLK      : serial clock to the A2D, idles high
//   MOSI      : serial command data to the A2D
//   MISO      : serial result data from the A2D
// modport master : the SPI master side (a2d_spi_master)
// modport slave  : the environment side (requester plus A2D pins)
// ---------------------------------------------------------------------------
interface a2d_spi_master_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  strt_cnv,
        input  chnnl,
        input  MISO,
        output cnv_cmplt,
        output res,
        output SS_n,
        output SCLK,
        output MOSI
    );

    modport slave (
        output strt_cnv,
        output chnnl,
        output MISO,
        input  cnv_cmplt,
        input  res,
        input  SS_n,
        input  SCLK,
        input  MOSI
    );
endinterface

// File: rtl/a2d_spi_master.sv
// ---------------------------------------------------------------------------
// a2d_spi_master
// Runs one conversion on the 12-bit, 8-channel SPI A2D: a 32-SCLK frame made
// of a 16-bit command word followed by a 16-bit result word, SS_n low
// throughout. Both words carry the same channel command; the result is taken
// from the low 12 bits of the second word.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : a2d_spi_master_if.master (handshake, result and SPI pins)
// Parameters:
//   DIV_W : SCLK divider width, SCLK period = 2^DIV_W clk (minimum 5)
// ---------------------------------------------------------------------------
module a2d_spi_master #(
    parameter int unsigned DIV_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    a2d_spi_master_if.master  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StBackPorch
    } state_t;

    // Shift point: 2 clk after SCLK rises (divider MSB set, LSBs == 1).
    localparam logic [DIV_W-1:0] DivShift = DIV_W'((1 << (DIV_W - 1)) + 1);
    // Front porch: first SCLK fall comes 9 clk after SS_n falls.
    localparam logic [DIV_W-1:0] DivFront = DIV_W'((1 << DIV_W) - 9);
    localparam logic [DIV_W-1:0] DivMax   = '1;

    state_t            r_state,     w_state_nxt;
    logic [DIV_W-1:0]  r_sclk_div,  w_sclk_div_nxt;
    logic [15:0]       r_shreg,     w_shreg_nxt;
    logic [5:0]        r_shft_cnt,  w_shft_cnt_nxt;
    logic [2:0]        r_chnnl,     w_chnnl_nxt;
    logic              r_ss_n,      w_ss_n_nxt;
    logic              r_cnv_cmplt, w_cnv_cmplt_nxt;
    logic [11:0]       r_res,       w_res_nxt;
    logic              w_shift;

    assign w_shift = (r_sclk_div == DivShift);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_sclk_div  <= DivMax;
            r_shreg     <= '0;
            r_shft_cnt  <= '0;
            r_chnnl     <= '0;
            r_ss_n      <= 1'b1;
            r_cnv_cmplt <= 1'b0;
            r_res       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sclk_div  <= w_sclk_div_nxt;
            r_shreg     <= w_shreg_nxt;
            r_shft_cnt  <= w_shft_cnt_nxt;
            r_chnnl     <= w_chnnl_nxt;
            r_ss_n      <= w_ss_n_nxt;
            r_cnv_cmplt <= w_cnv_cmplt_nxt;
            r_res       <= w_res_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sclk_div_nxt  = r_sclk_div;
        w_shreg_nxt     = r_shreg;
        w_shft_cnt_nxt  = r_shft_cnt;
        w_chnnl_nxt     = r_chnnl;
        w_ss_n_nxt      = r_ss_n;
        w_cnv_cmplt_nxt = r_cnv_cmplt;
        w_res_nxt       = r_res;

        unique case (r_state)
            StIdle: begin
                if (bus.strt_cnv) begin
                    w_ss_n_nxt      = 1'b0;
                    w_cnv_cmplt_nxt = 1'b0;
                    w_shreg_nxt     = {2'b00, bus.chnnl, 11'h000};
                    w_chnnl_nxt     = bus.chnnl;
                    w_sclk_div_nxt  = DivFront;
                    w_shft_cnt_nxt  = '0;
                    w_state_nxt     = StXfer;
                end
            end

            StXfer: begin
                w_sclk_div_nxt = r_sclk_div + 1'b1;
                if (w_shift) begin
                    w_shft_cnt_nxt = r_shft_cnt + 6'd1;
                    if (r_shft_cnt == 6'd15) begin
                        // Word 2 resends the command; word-1 junk is dropped.
                        w_shreg_nxt = {2'b00, r_chnnl, 11'h000};
                    end else begin
                        w_shreg_nxt = {r_shreg[14:0], bus.MISO};
                    end
                    if (r_shft_cnt == 6'd31) begin
                        w_state_nxt = StBackPorch;
                    end
                end
            end

            StBackPorch: begin
                // Divider stops at all-ones so SCLK stays high into idle.
                if (r_sclk_div == DivMax) begin
                    w_ss_n_nxt      = 1'b1;
                    w_res_nxt       = r_shreg[11:0];
                    w_cnv_cmplt_nxt = 1'b1;
                    w_state_nxt     = StIdle;
                end else begin
                    w_sclk_div_nxt = r_sclk_div + 1'b1;
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign bus.SCLK      = r_sclk_div[DIV_W-1];
    assign bus.MOSI      = r_shreg[15];
    assign bus.SS_n      = r_ss_n;
    assign bus.cnv_cmplt = r_cnv_cmplt;
    assign bus.res       = r_res;

endmodule

// File: tb/tb_a2d_spi_master.sv
// ---------------------------------------------------------------------------
// tb_a2d_spi_master
// Self-checking bench for a2d_spi_master. An A2D slave model decodes the
// channel from the command word and returns entry slot*8+channel of a data
// table on the second word.
// ---------------------------------------------------------------------------
module tb_a2d_spi_master;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    a2d_spi_master_if bus ();

    a2d_spi_master #(
        .DIV_W (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // A2D data table and the slot the slave reads from (written by the test).
    logic [11:0] mem [64];
    int          slot = 0;

    // Slave / monitor state, sampled on the falling clk edge.
    int          mon_cyc        = 0;
    int          fall_cnt       = 0;
    int          ss_fall_cyc    = 0;
    int          first_fall_cyc = 0;
    int          n_ss_rise      = 0;
    logic [31:0] mosi_w         = '0;
    logic        sclk_at_ssfall = 1'b0;
    logic        sclk_at_ssrise = 1'b0;
    logic        prev_ss        = 1'b1;
    logic        prev_sclk      = 1'b1;
    logic [2:0]  ch_dec         = '0;
    logic [15:0] word2          = '0;

    always @(negedge clk) begin
        mon_cyc++;
        if (prev_ss && !bus.SS_n) begin
            fall_cnt       = 0;
            mosi_w         = '0;
            ss_fall_cyc    = mon_cyc;
            first_fall_cyc = -1;
            sclk_at_ssfall = bus.SCLK;
        end
        if (!prev_ss && bus.SS_n) begin
            n_ss_rise++;
            sclk_at_ssrise = bus.SCLK;
        end
        if (prev_sclk && !bus.SCLK && !bus.SS_n) begin
            fall_cnt++;
            if (fall_cnt == 1) first_fall_cyc = mon_cyc;
            mosi_w = {mosi_w[30:0], bus.MOSI};
            if (fall_cnt == 16) begin
                ch_dec = mosi_w[13:11];
                word2  = {4'b0000, mem[slot * 8 + int'(ch_dec)]};
            end
            // The A2D shifts out each result bit on the SCLK fall.
            if (fall_cnt >= 17 && fall_cnt <= 32) bus.MISO = word2[32 - fall_cnt];
            else bus.MISO = 1'($urandom);
        end else if (bus.SS_n) begin
            bus.MISO = 1'($urandom);
        end
        prev_ss   = bus.SS_n;
        prev_sclk = bus.SCLK;
    end

    typedef struct {
        logic [2:0]  ch;
        int          slt;
        logic [11:0] data;
        logic [15:0] exp_cmd;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Caller sits #1 after a rising edge. Returns #1 after the edge where
    // cnv_cmplt was first seen high (lat = -1 on timeout).
    task automatic run_conv(input logic [2:0] ch, input bit noisy, output int lat,
                            output bit glitch);
        bus.chnnl    = ch;
        bus.strt_cnv = 1'b1;
        @(posedge clk);
        #1;
        bus.strt_cnv = 1'b0;
        chk("ss_n_falls_1clk", int'(bus.SS_n), 0);
        chk("cmplt_cleared_on_start", int'(bus.cnv_cmplt), 0);
        lat    = -1;
        glitch = 1'b0;
        for (int k = 1; k <= 1200; k++) begin
            bus.chnnl = 3'($urandom);
            if (noisy) bus.strt_cnv = (k % 50 == 0) || (k == 1033);
            @(posedge clk);
            #1;
            if (bus.cnv_cmplt) begin
                lat = k;
                break;
            end
            if (bus.SS_n) glitch = 1'b1;
        end
        bus.strt_cnv = 1'b0;
    endtask

    task automatic verify(input string tag, input logic [11:0] exp_res,
                          input logic [15:0] exp_cmd, input int lat);
        chk_rng({tag, "_latency"}, lat, 1030, 1038);
        chk({tag, "_res"}, int'(bus.res), int'(exp_res));
        @(negedge clk);
        #1;
        chk({tag, "_sclk_falls"}, fall_cnt, 32);
        chk({tag, "_mosi_word1"}, int'(mosi_w[31:16]), int'(exp_cmd));
        chk({tag, "_mosi_word2"}, int'(mosi_w[15:0]), int'(exp_cmd));
        chk({tag, "_sclk_hi_at_ss_fall"}, int'(sclk_at_ssfall), 1);
        chk({tag, "_sclk_hi_at_ss_rise"}, int'(sclk_at_ssrise), 1);
        chk({tag, "_front_porch"}, first_fall_cyc - ss_fall_cyc, 9);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          lat;
        bit          glitch;
        logic [2:0]  ch;
        logic [11:0] exp;
        int          rises0;

        tbl[0] = '{ch: 3'd5, slt: 0, data: 12'hA5C, exp_cmd: 16'h2800};
        tbl[1] = '{ch: 3'd6, slt: 1, data: 12'h3C7, exp_cmd: 16'h3000};
        tbl[2] = '{ch: 3'd0, slt: 2, data: 12'hFFF, exp_cmd: 16'h0000};
        tbl[3] = '{ch: 3'd7, slt: 3, data: 12'h001, exp_cmd: 16'h3800};
        tbl[4] = '{ch: 3'd3, slt: 4, data: 12'h800, exp_cmd: 16'h1800};
        tbl[5] = '{ch: 3'd1, slt: 5, data: 12'h000, exp_cmd: 16'h0800};

        for (int i = 0; i < 64; i++) mem[i] = 12'($urandom);

        rst_n        = 1'b0;
        bus.strt_cnv = 1'b0;
        bus.chnnl    = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ss_n", int'(bus.SS_n), 1);
        chk("reset_sclk", int'(bus.SCLK), 1);
        chk("reset_cmplt", int'(bus.cnv_cmplt), 0);
        chk("reset_res", int'(bus.res), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            slot = tbl[i].slt;
            mem[tbl[i].slt * 8 + int'(tbl[i].ch)] = tbl[i].data;
            run_conv(tbl[i].ch, 1'b0, lat, glitch);
            verify($sformatf("tbl%0d", i), tbl[i].data, tbl[i].exp_cmd, lat);
        end

        // Random channels and slots against the data-table model.
        for (int i = 0; i < 12; i++) begin
            ch   = 3'($urandom);
            slot = int'($urandom_range(0, 7));
            exp  = mem[slot * 8 + int'(ch)];
            run_conv(ch, 1'b0, lat, glitch);
            verify($sformatf("rnd%0d", i), exp, {2'b00, ch, 11'h000}, lat);
        end

        // Back-to-back: new request the cycle after each completion.
        for (int n = 0; n < 8; n++) begin
            slot = n;
            run_conv(3'(n), 1'b0, lat, glitch);
            chk_rng($sformatf("b2b%0d_latency", n), lat, 1030, 1038);
            chk($sformatf("b2b%0d_res", n), int'(bus.res), int'(mem[n * 8 + n]));
        end
        @(negedge clk);
        @(posedge clk);
        #1;

        // Requests during a frame (including the completion cycle) are ignored.
        slot        = 6;
        mem[6 * 8 + 2] = 12'h5A3;
        rises0      = n_ss_rise;
        run_conv(3'd2, 1'b1, lat, glitch);
        chk("ign_ss_n_continuous", int'(glitch), 0);
        verify("ign", 12'h5A3, 16'h1000, lat);
        repeat (20) @(posedge clk);
        #1;
        chk("ign_no_second_frame_ss_n", int'(bus.SS_n), 1);
        chk("ign_cmplt_held", int'(bus.cnv_cmplt), 1);
        chk("ign_single_frame", n_ss_rise - rises0, 1);

        // Asynchronous reset in the middle of a transfer.
        bus.chnnl    = 3'd4;
        bus.strt_cnv = 1'b1;
        @(posedge clk);
        #1;
        bus.strt_cnv = 1'b0;
        repeat (300) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ss_n", int'(bus.SS_n), 1);
        chk("midrst_sclk", int'(bus.SCLK), 1);
        chk("midrst_cmplt", int'(bus.cnv_cmplt), 0);
        chk("midrst_res", int'(bus.res), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        slot           = 7;
        mem[7 * 8 + 4] = 12'h9E1;
        run_conv(3'd4, 1'b0, lat, glitch);
        verify("post_rst", 12'h9E1, 16'h2000, lat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/a2d_spi_master.md
Name: a2d_spi_master

Overview:
SPI master that runs one conversion on the 12-bit, 8-channel SPI A2D converter. The converter sits directly downstream of this block.
- A conversion is one 32-SCLK frame made of two back-to-back 16-bit words, with SS_n held low for the whole frame.
- Word 1 sends the channel command. Word 2 returns the conversion result.
- Sits between the line-sensor sampling logic (upstream, drives strt_cnv/chnnl) and the A2D pins.

Parameters:
DIV_W, 5, SCLK divider width; SCLK period = 2^DIV_W clk (32 at default). All cycle counts below assume the default.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
strt_cnv  in  1  single-cycle request to start a conversion; honoured only in IDLE
chnnl  in  3  channel to convert; sampled only on the accepted strt_cnv cycle
cnv_cmplt  out  1  level; high once a result is valid, cleared on next accepted strt_cnv
res  out  12  last conversion result; held until next completion
SS_n  out  1  active-low slave select to A2D
SCLK  out  1  serial clock to A2D, idles high
MOSI  out  1  serial data to A2D
MISO  in  1  serial data from A2D; may be high-Z when SS_n is high

Behaviour:
- Reset values: SS_n=1, SCLK=1, cnv_cmplt=0, res=12'h000, state=IDLE, sclk_div=5'b11111, shift count=0.
- SCLK is always driven as sclk_div[4], a flop output, so it is glitch-free.
  - Fall occurs when sclk_div wraps 11111->00000.
  - Rise occurs when sclk_div goes 01111->10000.
  - sclk_div is held at 11111 in IDLE.
- Shift register: 16 bits. MOSI = shreg[15].
  - A "shift" samples MISO into shreg[0] and moves shreg left by one.
  - A shift occurs on the cycle sclk_div==5'b10001, i.e. 2 clk after each SCLK rise.
  - MISO is therefore sampled mid-high-phase, and MOSI changes well before the A2D samples it on the falling edge.
- Command word: {2'b00, chnnl, 11'h000}. The channel lands in bits [13:11] as the A2D expects.
- States:
  - IDLE: on strt_cnv
    - SS_n<=0, cnv_cmplt<=0.
    - shreg<=command; the chnnl value is also latched.
    - sclk_div<=5'b10111 (front porch: first SCLK fall 9 clk after SS_n falls).
    - shift count<=0, go XFER.
    - strt_cnv in any other state is ignored.
  - XFER:
    - sclk_div free-runs.
    - Shift count increments on each shift.
    - On shift 16: shreg is reloaded with the latched command instead of shifting. Word 2 resends the same channel; the junk LSB of word 1 is discarded.
    - On shift 32: perform the shift, go BACK_PORCH.
  - BACK_PORCH:
    - sclk_div increments but must not wrap; SCLK stays high.
    - When sclk_div==11111: SS_n<=1, res<=shreg[11:0], cnv_cmplt<=1, go IDLE.
- Frame contents:
  - Exactly 32 SCLK falls and 32 rises per conversion.
  - Word 1 (rises 1–16) MISO data is don't-care.
  - Word 2 (rises 17–32) delivers {4'b0000, result[11:0]} MSB first.
- Latency: SS_n falls 1 clk after strt_cnv. cnv_cmplt rises ~1034 clk after the strt_cnv edge.
- Boundaries:
  - Reset mid-frame immediately returns all outputs to reset values, and SS_n goes high the same cycle (async).
  - strt_cnv asserted on the same cycle cnv_cmplt rises is ignored, since the block is not yet in IDLE.
  - strt_cnv in IDLE with cnv_cmplt=1 starts a new frame and clears cnv_cmplt.
  - chnnl changes during a frame have no effect.

Test Plan:
- Reset mid-XFER (after ~300 clk) -> same cycle SS_n=1, SCLK=1, cnv_cmplt=0, res=0; a subsequent strt_cnv completes normally.
- Single conversion, chnnl=3'd5, against the A2D slave model with a data file whose entry 5 = 12'hA5C -> exactly 32 SCLK falls while SS_n low; res=12'hA5C; cnv_cmplt=1 within 1030–1038 clk of strt_cnv.
- MOSI check: chnnl=3'd6, capture MOSI at each SCLK fall -> both words equal 16'h3000; SCLK high at SS_n fall and rise; first fall 9 clk after SS_n fall.
- Back-to-back: 8 conversions, chnnl 0..7, strt_cnv issued the cycle after each cnv_cmplt -> res[n] = data entry n*8+n; cnv_cmplt drops the cycle after each new strt_cnv.
- Ignored requests: pulse strt_cnv every 50 clk during a frame, with chnnl toggling -> only one frame, result for the originally latched channel, SS_n low continuously.
